noc_out_arbiter: RTL
====================

Name: noc_out_arbiter

Overview:
- Output-port scheduler for one NoC router link: shares a single 16-bit output channel among NUM_IN input flit queues.
- Packet-granular round-robin arbitration: a winner keeps the link for exactly PKT_LEN flits.
- Drives each queue's grant/pop handshake, muxes the returned flits onto the link and tracks downstream buffer credits.

Parameters:
- NUM_IN, 5, number of input queues competing for the port
- FLIT_W, 16, flit width in bits
- PKT_LEN, 5, flits per packet (pops issued per grant)
- CREDITS, 5, downstream buffer depth; initial credit count

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req_i  in  NUM_IN  queue i holds at least one complete packet
- mask_i  in  NUM_IN  queue i is mid-packet (from queue mask output)
- valid_i  in  NUM_IN  queue i flit valid (one cycle after its pop)
- data_i  in  NUM_IN*FLIT_W  queue i flit, slice i at [i*FLIT_W +: FLIT_W]
- credit_i  in  1  downstream freed one slot (pulse)
- grant_o  out  NUM_IN  one-hot packet grant, single-cycle pulse
- pop_o  out  NUM_IN  one-hot per-flit pop request
- data_o  out  FLIT_W  registered output flit
- valid_o  out  1  registered output flit valid
- busy_o  out  1  packet transfer in progress
- sel_o  out  $clog2(NUM_IN)  current/last winner index

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock. Reset values: state=IDLE, grant_o=0, pop_o=0, data_o=0, valid_o=0, busy_o=0, sel_o=0, rr pointer=NUM_IN-1 (input 0 has top priority first), credit_cnt=CREDITS, flit_cnt=0.
- Reset mid-packet: abandon the transfer with no further pops; the queues are reset by the same rst.
- FSM states: IDLE, XFER.
- IDLE → XFER:
  - Condition: any req_i=1 and credit_cnt>0.
  - Winner w is the first requester searching from pointer+1 (mod NUM_IN).
  - Same cycle: grant_o[w]=1 and pop_o[w]=1, pointer<=w, sel<=w, flit_cnt<=1, busy_o<=1.
  - A requester with mask_i=1 is ineligible.
- XFER:
  - pop_o[sel]=1 in each cycle that credit_cnt>0; flit_cnt increments per pop.
  - credit_cnt=0 stalls with no pop; the FSM stays in XFER.
  - When the pop bringing flit_cnt to PKT_LEN issues, go to IDLE next cycle. New arbitration may occur in that IDLE cycle.
  - grant_o is never asserted in XFER.
- Credits:
  - Decrement on each pop; increment on credit_i.
  - Both in the same cycle: unchanged.
  - Saturate at CREDITS (extra credit_i ignored); never underflow.
- Datapath:
  - sel_d = sel registered one cycle, tracking queue pop→valid latency.
  - data_o/valid_o are registered from data_i[sel_d]/valid_i[sel_d].
  - pop_o→valid_o latency is 2 cycles.
  - data_o holds its last value when valid_o=0.
- No req_i: stay IDLE, all pulses 0.
- busy_o=1 exactly while in XFER.

Optional Feature:
- Macro: NOC_ARB_PRIO_EN.
- Defined:
  - Adds input prio_i[NUM_IN].
  - Eligible requesters with prio_i=1 win over all others; round-robin among the high-priority set; the pointer updates as normal.
- Undefined: the port is absent; pure round-robin.

Decomposition:
- Package noc_pkg:
  - FLIT_W, PKT_LEN, CREDITS constants
  - arb_state_t enum {IDLE, XFER}
  - flit_t typedef logic [FLIT_W-1:0]
- Sub-module rr_arbiter: combinational masked round-robin picker. Inputs: request vector, pointer. Outputs: one-hot grant and index. Instantiated once.

Test Plan:
- req_i=5'b00001, credits full → grant_o=00001 for 1 cycle; pop_o[0] high 5 consecutive cycles; valid_o high cycles 3–7 with data_o = queue 0 flits in order.
- req_i=5'b10101 held → packets granted in order 0, 2, 4, 0; each winner receives exactly 5 pops; no grant while busy_o=1.
- CREDITS=5, credit_i=0 → stall after 5 pops (credit_cnt=0); a single credit_i pulse releases exactly one pop; second packet starts only after credits return.
- credit_i coincident with a pop → credit_cnt unchanged; credit_i pulses at full count → stays 5.
- rst asserted at flit 3 of a packet → next cycle pop_o=0, valid_o=0, credit_cnt=5, state IDLE; re-arbitration starts from input 0.
- With NOC_ARB_PRIO_EN: req_i=11111, prio_i=01000 → input 3 wins consecutive packets while prio_i[3] and req_i[3] are held.

Source files
------------

// File: rtl/noc_out_arbiter_pkg.sv
// rtl/noc_out_arbiter_pkg.sv - shared constants and types for the router output-port arbiter
package noc_pkg;

  localparam int FLIT_W  = 16;
  localparam int PKT_LEN = 5;
  localparam int CREDITS = 5;

  typedef enum logic {IDLE, XFER} arb_state_t;

  typedef logic [FLIT_W-1:0] flit_t;

endpackage

// File: rtl/noc_out_arbiter_if.sv
// rtl/noc_out_arbiter_if.sv - queue-side and link-side signals of one output port
// NOC_ARB_PRIO_EN adds the per-queue prio_i vector.
interface noc_out_arbiter_if
  import noc_pkg::*;
#(
  parameter int NUM_IN = 5
) ();

  logic [NUM_IN-1:0]        req_i;
  logic [NUM_IN-1:0]        mask_i;
  logic [NUM_IN-1:0]        valid_i;
  logic [NUM_IN*FLIT_W-1:0] data_i;
  logic                     credit_i;
`ifdef NOC_ARB_PRIO_EN
  logic [NUM_IN-1:0]        prio_i;
`endif
  logic [NUM_IN-1:0]        grant_o;
  logic [NUM_IN-1:0]        pop_o;
  flit_t                    data_o;
  logic                     valid_o;
  logic                     busy_o;
  logic [$clog2(NUM_IN)-1:0] sel_o;

  modport master (
`ifdef NOC_ARB_PRIO_EN
    input  prio_i,
`endif
    input  req_i, mask_i, valid_i, data_i, credit_i,
    output grant_o, pop_o, data_o, valid_o, busy_o, sel_o
  );

  modport slave (
`ifdef NOC_ARB_PRIO_EN
    output prio_i,
`endif
    output req_i, mask_i, valid_i, data_i, credit_i,
    input  grant_o, pop_o, data_o, valid_o, busy_o, sel_o
  );

endinterface

// File: rtl/noc_out_arbiter_rr_arbiter.sv
// rtl/noc_out_arbiter_rr_arbiter.sv - combinational round-robin picker
// Searches from ptr+1 upward (mod NUM_IN); the first set request wins.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = 5,
  localparam int IDX_W = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      pos = IDX_W'((int'(ptr) + k) % NUM_IN);
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// rtl/noc_out_arbiter.sv - packet-granular round-robin scheduler for one router output link
// NOC_ARB_PRIO_EN: eligible requesters with prio_i set win over all others at packet boundaries.
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_IN = 5
) (
  input logic              clk,
  input logic              rst,
  noc_out_arbiter_if.master bus
);

  localparam int IDX_W  = $clog2(NUM_IN);
  localparam int CNT_W  = $clog2(CREDITS + 1);
  localparam int FCNT_W = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(CREDITS);
  localparam logic [FCNT_W-1:0] LAST_POP   = FCNT_W'(PKT_LEN - 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  sel_q;
  logic [IDX_W-1:0]  sel_d;
  logic [CNT_W-1:0]  credit_cnt;
  logic [FCNT_W-1:0] flit_cnt;
  logic [NUM_IN-1:0] grant_q;
  logic [NUM_IN-1:0] pop_q;
  logic              busy_q;
  logic              valid_q;
  flit_t             data_q;

  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] pick_req;
  logic [NUM_IN-1:0] win_onehot;
  logic [IDX_W-1:0]  win_idx;
  logic              win_any;
  logic              has_credit;
  logic              start;
  logic              pop_fire;

  // A queue that is mid-packet cannot be granted a new packet.
  assign eligible = bus.req_i & ~bus.mask_i;

`ifdef NOC_ARB_PRIO_EN
  logic [NUM_IN-1:0] hi_req;
  assign hi_req   = eligible & bus.prio_i;
  assign pick_req = (|hi_req) ? hi_req : eligible;
`else
  assign pick_req = eligible;
`endif

  rr_arbiter #(.NUM_IN(NUM_IN)) u_rr (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

  assign has_credit = (credit_cnt != '0);
  assign start      = (state == IDLE) && win_any && has_credit;
  assign pop_fire   = start || ((state == XFER) && has_credit);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_q  <= '0;
      pop_q    <= '0;
      busy_q   <= 1'b0;
      sel_q    <= '0;
      rr_ptr   <= IDX_W'(NUM_IN - 1);
      flit_cnt <= '0;
    end else begin
      grant_q <= '0;
      pop_q   <= '0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= XFER;
            grant_q  <= win_onehot;
            pop_q    <= win_onehot;
            rr_ptr   <= win_idx;
            sel_q    <= win_idx;
            flit_cnt <= FCNT_W'(1);
            busy_q   <= 1'b1;
          end
        end
        XFER: begin
          if (has_credit) begin
            pop_q    <= NUM_IN'(1) << sel_q;
            flit_cnt <= flit_cnt + FCNT_W'(1);
            // Leave as the final pop issues so the next grant can follow back-to-back.
            if (flit_cnt == LAST_POP) begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      credit_cnt <= CREDIT_MAX;
    end else begin
      case ({pop_fire, bus.credit_i})
        2'b10:   credit_cnt <= credit_cnt - CNT_W'(1);
        2'b01:   if (credit_cnt != CREDIT_MAX) credit_cnt <= credit_cnt + CNT_W'(1);
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

  // sel_d lines up with the queue's one-cycle pop-to-valid latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_d   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      sel_d   <= sel_q;
      valid_q <= bus.valid_i[sel_d];
      if (bus.valid_i[sel_d]) begin
        data_q <= bus.data_i[int'(sel_d) * FLIT_W +: FLIT_W];
      end
    end
  end

  assign bus.grant_o = grant_q;
  assign bus.pop_o   = pop_q;
  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
  assign bus.sel_o   = sel_q;

endmodule
